hs_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares one 8-bit valid/ready handshake channel (the slave side) between NUM_REQ valid/ready masters.
- Arbitrates per packet. The grant is locked from the first beat until the beat carrying last completes its handshake.
- Sits between the master_*_hs instances and a single slave_*_hs instance inside the handshake test top.

---
 rtl/hs_rr_arbiter.sv | 114 +++++++++++
 tb/tb_hs_rr_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hs_rr_arbiter.sv
`default_nettype none
// ==========================================================================
// hs_rr_arbiter : packet-locked round-robin arbiter onto one valid/ready link
// Revision      : 1.0
// ==========================================================================
module hs_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int IDX_W   = 2
) (
  input  logic                      aclk,
  input  logic                      rstn,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  output logic                      out_last,
  input  logic                      out_ready,
  output logic [IDX_W-1:0]          grant_idx,
  output logic                      busy,
  output logic [7:0]                pkt_cnt
);

  localparam logic [IDX_W:0] NREQ = (IDX_W+1)'(NUM_REQ);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_found;
  logic [IDX_W:0]   cand;
  logic [IDX_W:0]   ptr_inc;
  logic [IDX_W-1:0] next_ptr;
  logic             pkt_done;

  logic [DATA_W-1:0] lane_data [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    assign lane_data[i] = req_data[i*DATA_W +: DATA_W];
  end

  // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = rr_ptr;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr} + (IDX_W+1)'(k);
      if (cand >= NREQ) begin
        cand = cand - NREQ;
      end
      if (!sel_found && req_valid[cand[IDX_W-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = cand[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    ptr_inc  = {1'b0, grant_idx} + {{IDX_W{1'b0}}, 1'b1};
    next_ptr = (ptr_inc == NREQ) ? '0 : ptr_inc[IDX_W-1:0];
  end

  // Data path is a pure pass-through of the owner; nothing is buffered.
  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    req_ready = '0;
    if (state == GRANT) begin
      out_valid            = req_valid[grant_idx];
      out_data             = lane_data[grant_idx];
      out_last             = req_last[grant_idx];
      req_ready[grant_idx] = out_ready;
    end
  end

  assign busy     = (state == GRANT);
  assign pkt_done = out_valid && out_ready && out_last;

  always_ff @(posedge aclk) begin
    if (!rstn) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      grant_idx <= '0;
      pkt_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_found) begin
            grant_idx <= sel_idx;
            state     <= GRANT;
          end
        end
        GRANT: begin
          if (pkt_done) begin
            state   <= IDLE;
            rr_ptr  <= next_ptr;
            pkt_cnt <= pkt_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hs_rr_arbiter.sv
`default_nettype none
// Scoreboard bench for hs_rr_arbiter: per-master beat queues drive the inputs,
// expected beats (owner, data, last, cycle) are queued and checked on each handshake.
module tb_hs_rr_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 8;
  localparam int IDX_W   = 2;

  logic                      clk;
  logic                      rstn;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_last;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      out_valid;
  logic [DATA_W-1:0]         out_data;
  logic                      out_last;
  logic                      out_ready;
  logic [IDX_W-1:0]          grant_idx;
  logic                      busy;
  logic [7:0]                pkt_cnt;

  hs_rr_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .IDX_W(IDX_W)) dut (
    .aclk      (clk),
    .rstn      (rstn),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready),
    .grant_idx (grant_idx),
    .busy      (busy),
    .pkt_cnt   (pkt_cnt)
  );

  typedef struct {
    logic [7:0] data;
    logic       last;
    int         gap;
  } beat_t;

  typedef struct {
    int         idx;
    logic [7:0] data;
    logic       last;
    int         cyc;
  } exp_t;

  beat_t      mq [NUM_REQ][$];
  exp_t       exp_q [$];
  int         gapcnt [NUM_REQ];
  bit         loaded [NUM_REQ];
  bit         hs [NUM_REQ];
  int         cyc;
  int         n_vec;
  int         n_miss;
  logic [7:0] exp_pkts;
  int         t0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic chk(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic bit all_idle();
    bit r = (exp_q.size() == 0);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (mq[i].size() != 0) r = 1'b0;
    end
    return r;
  endfunction

  task automatic push_exp(input int idx, input logic [7:0] d, input logic l, input int c);
    exp_t e;
    e.idx = idx; e.data = d; e.last = l; e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic push_beat(input int m, input logic [7:0] d, input logic l, input int gap);
    beat_t b;
    b.data = d; b.last = l; b.gap = gap;
    mq[m].push_back(b);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (!all_idle() && n < budget) begin
      step();
      n++;
    end
    if (!all_idle()) begin
      n_vec++;
      n_miss++;
      $display("FAIL drain_timeout: %0d beats still expected, required 0", exp_q.size());
      exp_q.delete();
      for (int i = 0; i < NUM_REQ; i++) mq[i].delete();
    end
  endtask

  // Master models: present the head beat after its gap, hold it until accepted.
  initial begin
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      gapcnt[i] = 0;
      loaded[i] = 1'b0;
    end
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (hs[i] && mq[i].size() > 0) begin
          void'(mq[i].pop_front());
          loaded[i] = 1'b0;
        end
        if (mq[i].size() == 0) begin
          loaded[i]    = 1'b0;
          req_valid[i] = 1'b0;
        end else begin
          if (!loaded[i]) begin
            gapcnt[i] = mq[i][0].gap;
            loaded[i] = 1'b1;
          end
          if (gapcnt[i] > 0) begin
            gapcnt[i]--;
            req_valid[i] = 1'b0;
          end else begin
            req_valid[i]                   = 1'b1;
            req_data[i*DATA_W +: DATA_W] = mq[i][0].data;
            req_last[i]                    = mq[i][0].last;
          end
        end
      end
    end
  end

  // Monitor: every slave-side handshake must match the head of the scoreboard.
  initial begin
    exp_t e;
    for (int i = 0; i < NUM_REQ; i++) hs[i] = 1'b0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NUM_REQ; i++) hs[i] = req_valid[i] && req_ready[i];
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL unexpected_beat: got data 0x%0h from %0d, required no beat (cycle %0d)",
                   out_data, grant_idx, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("beat_owner", int'(grant_idx), e.idx);
          chk("beat_data",  int'(out_data),  int'(e.data));
          chk("beat_last",  int'(out_last),  int'(e.last));
          chk("beat_cycle", cyc,             e.cyc);
        end
      end
    end
  end

  initial begin
    n_vec    = 0;
    n_miss   = 0;
    exp_pkts = 8'd0;
    rstn     = 1'b0;
    out_ready = 1'b1;

    // Reset held with every master requesting.
    step();
    for (int i = 0; i < NUM_REQ; i++) push_beat(i, 8'(8'h10 + i), 1'b1, 0);
    step();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_req_ready", int'(req_ready), 0);
      chk("rst_busy",      int'(busy),      0);
      chk("rst_pkt_cnt",   int'(pkt_cnt),   0);
      step();
    end
    t0 = cyc;
    for (int i = 0; i < NUM_REQ; i++) push_exp(i, 8'(8'h10 + i), 1'b1, t0 + 1 + 2*i);
    exp_pkts += 8'd4;
    rstn = 1'b1;
    @(negedge clk);
    chk("rel_grant_idx", int'(grant_idx), 0);
    chk("rel_busy",      int'(busy),      0);
    wait_drain(100);
    chk("rst_seq_pkt_cnt", int'(pkt_cnt), int'(exp_pkts));

    // Single master, three beats.
    t0 = cyc;
    push_beat(2, 8'hA1, 1'b0, 0);
    push_beat(2, 8'hA2, 1'b0, 0);
    push_beat(2, 8'hA3, 1'b1, 0);
    push_exp(2, 8'hA1, 1'b0, t0 + 2);
    push_exp(2, 8'hA2, 1'b0, t0 + 3);
    push_exp(2, 8'hA3, 1'b1, t0 + 4);
    exp_pkts += 8'd1;
    repeat (4) step();
    @(negedge clk);
    chk("single_busy_last", int'(busy), 1);
    step();
    @(negedge clk);
    chk("single_busy_after", int'(busy), 0);
    chk("single_pkt_cnt", int'(pkt_cnt), int'(exp_pkts));
    wait_drain(50);

    // Pointer now 3: with masters 0 and 3 requesting, 3 wins first.
    t0 = cyc;
    push_beat(0, 8'h30, 1'b1, 0);
    push_beat(3, 8'h33, 1'b1, 0);
    push_exp(3, 8'h33, 1'b1, t0 + 2);
    push_exp(0, 8'h30, 1'b1, t0 + 4);
    exp_pkts += 8'd2;
    wait_drain(50);

    // Full contention, two 2-beat packets per master; pointer starts at 1.
    t0 = cyc;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        push_beat(i, 8'(i), 1'b0, 0);
        push_beat(i, 8'(i), 1'b1, 0);
      end
    end
    for (int k = 0; k < 8; k++) begin
      push_exp((1 + k) % NUM_REQ, 8'((1 + k) % NUM_REQ), 1'b0, t0 + 2 + 3*k);
      push_exp((1 + k) % NUM_REQ, 8'((1 + k) % NUM_REQ), 1'b1, t0 + 3 + 3*k);
    end
    exp_pkts += 8'd8;
    wait_drain(100);
    chk("contend_pkt_cnt", int'(pkt_cnt), int'(exp_pkts));

    // Backpressure on master 1 while master 3 waits.
    t0 = cyc;
    push_beat(1, 8'hB1, 1'b0, 0);
    push_beat(1, 8'hB2, 1'b0, 0);
    push_beat(1, 8'hB3, 1'b1, 0);
    push_beat(3, 8'hC3, 1'b1, 0);
    push_exp(1, 8'hB1, 1'b0, t0 + 2);
    push_exp(1, 8'hB2, 1'b0, t0 + 5);
    push_exp(1, 8'hB3, 1'b1, t0 + 6);
    push_exp(3, 8'hC3, 1'b1, t0 + 8);
    exp_pkts += 8'd2;
    step();
    step();
    step();
    out_ready = 1'b0;
    @(negedge clk);
    chk("stall1_data",  int'(out_data),  8'hB2);
    chk("stall1_grant", int'(grant_idx), 1);
    chk("stall1_ready", int'(req_ready), 0);
    step();
    @(negedge clk);
    chk("stall2_data",  int'(out_data),  8'hB2);
    chk("stall2_valid", int'(out_valid), 1);
    chk("stall2_busy",  int'(busy),      1);
    step();
    out_ready = 1'b1;
    wait_drain(50);

    // Master 0 drops valid for three cycles mid-packet; master 1 waits.
    t0 = cyc;
    push_beat(0, 8'hD1, 1'b0, 0);
    push_beat(0, 8'hD2, 1'b1, 3);
    push_beat(1, 8'hE1, 1'b1, 0);
    push_exp(0, 8'hD1, 1'b0, t0 + 2);
    push_exp(0, 8'hD2, 1'b1, t0 + 6);
    push_exp(1, 8'hE1, 1'b1, t0 + 8);
    exp_pkts += 8'd2;
    repeat (4) step();
    @(negedge clk);
    chk("gap_busy",      int'(busy),      1);
    chk("gap_grant",     int'(grant_idx), 0);
    chk("gap_out_valid", int'(out_valid), 0);
    chk("gap_ready1",    int'(req_ready[1]), 0);
    wait_drain(50);
    chk("gap_pkt_cnt", int'(pkt_cnt), int'(exp_pkts));

    // Reset during beat 2 of a 4-beat packet from master 2.
    t0 = cyc;
    push_beat(2, 8'hF1, 1'b0, 0);
    push_beat(2, 8'hF2, 1'b0, 0);
    push_beat(2, 8'hF3, 1'b0, 0);
    push_beat(2, 8'hF4, 1'b1, 0);
    push_exp(2, 8'hF1, 1'b0, t0 + 2);
    push_exp(2, 8'hF2, 1'b0, t0 + 3);
    repeat (3) step();
    rstn = 1'b0;
    step();
    mq[2].delete();
    exp_pkts = 8'd0;
    @(negedge clk);
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_busy",      int'(busy),      0);
    chk("midrst_pkt_cnt",   int'(pkt_cnt),   0);
    chk("midrst_grant",     int'(grant_idx), 0);
    step();
    rstn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("post_rst_idle", int'(out_valid), 0);
      step();
    end

    // 256 single-beat packets wrap the packet counter back to zero.
    t0 = cyc;
    for (int j = 0; j < 64; j++) begin
      for (int i = 0; i < NUM_REQ; i++) push_beat(i, 8'(4*j + i), 1'b1, 0);
    end
    for (int k = 0; k < 256; k++) push_exp(k % NUM_REQ, 8'(k), 1'b1, t0 + 2 + 2*k);
    exp_pkts += 8'd0;
    wait_drain(1000);
    chk("wrap_pkt_cnt", int'(pkt_cnt), int'(exp_pkts));
    chk("wrap_busy",    int'(busy),    0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
